pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage of the pipelined RV32I core. It sits directly downstream of the controller and consumes its per-instruction pcOp/pcWriteData decision. It holds the architectural PC, computes the next PC, fetches the next instruction over a req/ack instruction-memory port, and presents it to the decoder with a valid flag. It also returns the link value (PC+4) to the controller as pcReadData.

---
 rtl/pc_fetch_unit_pkg.sv | 27 ++
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/pc_fetch_unit_pc_next_calc.sv | 26 ++
 rtl/pc_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: PC operation codes, bus widths and
// fetch FSM state encodings.
package pc_fetch_unit_pkg;

    localparam int PCOpWidth = 2;
    localparam int DataWidth = 32;
    localparam int AddrWidth = 32;

    typedef enum logic [PCOpWidth-1:0] {
        PCClear  = 2'd0,
        PCAdd4   = 2'd1,
        PCAddImm = 2'd2,
        PCSetImm = 2'd3
    } pcOp_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetchState_e;

    // Jump targets are word aligned; the two low bits are dropped.
    function automatic logic [AddrWidth-1:0] alignWord(input logic [AddrWidth-1:0] addr);
        return {addr[AddrWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge port. The fetch unit is the master;
// the memory is the slave.
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    logic                 imemReq;
    logic [AddrWidth-1:0] imemAddr;
    logic                 imemAck;
    logic [DataWidth-1:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemAck,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemAck,
        output imemData
    );

endinterface

// File: rtl/pc_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection from the controller's pcOp decision.
// All arithmetic wraps silently modulo 2^ADDR_WIDTH.
module pc_next_calc
    import pc_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [PCOpWidth-1:0]  pcOp,
    input  logic [ADDR_WIDTH-1:0] pcWriteData,
    output logic [ADDR_WIDTH-1:0] nextPc
);

    always_comb begin
        nextPc = pc + ADDR_WIDTH'(4);
        case (pcOp)
            PCClear:  nextPc = RESET_PC;
            PCAdd4:   nextPc = pc + ADDR_WIDTH'(4);
            PCAddImm: nextPc = pc + pcWriteData;
            PCSetImm: nextPc = alignWord(pcWriteData);
            default:  nextPc = pc + ADDR_WIDTH'(4);
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch stage. Defining FETCH_PREFETCH_EN adds a
// one-entry speculative prefetch of pc+4 while the current instruction is held.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [PCOpWidth-1:0]  pcOp,
    input  logic [DATA_WIDTH-1:0] pcWriteData,
    input  logic                  stepValid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pcReadData,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instrValid,
    pc_fetch_unit_if.master       imem
);

`ifdef FETCH_PREFETCH_EN
    localparam bit PrefetchEn = 1'b1;
`else
    localparam bit PrefetchEn = 1'b0;
`endif

    fetchState_e           stateReg, stateNext;
    logic [ADDR_WIDTH-1:0] pcReg, pcNext;
    logic [DATA_WIDTH-1:0] instrReg, instrNext;
    logic                  instrValidReg, instrValidNext;
    logic                  reqReg, reqNext;
    logic [ADDR_WIDTH-1:0] addrReg, addrNext;
    logic                  pfValidReg, pfValidNext;
    logic [DATA_WIDTH-1:0] pfDataReg, pfDataNext;
    logic                  dropReg, dropNext;

    logic [ADDR_WIDTH-1:0] nextPc;
    logic [ADDR_WIDTH-1:0] pcPlus4;
    logic                  ackSeen;

    pc_next_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_nextCalc (
        .pc          (pcReg),
        .pcOp        (pcOp),
        .pcWriteData (pcWriteData),
        .nextPc      (nextPc)
    );

    assign pcPlus4 = pcReg + ADDR_WIDTH'(4);
    // An ack only counts while a request is actually outstanding.
    assign ackSeen = reqReg & imem.imemAck;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateReg      <= BOOT;
            pcReg         <= RESET_PC;
            instrReg      <= '0;
            instrValidReg <= 1'b0;
            reqReg        <= 1'b0;
            addrReg       <= RESET_PC;
            pfValidReg    <= 1'b0;
            pfDataReg     <= '0;
            dropReg       <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            pcReg         <= pcNext;
            instrReg      <= instrNext;
            instrValidReg <= instrValidNext;
            reqReg        <= reqNext;
            addrReg       <= addrNext;
            pfValidReg    <= pfValidNext;
            pfDataReg     <= pfDataNext;
            dropReg       <= dropNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        pcNext         = pcReg;
        instrNext      = instrReg;
        instrValidNext = instrValidReg;
        reqNext        = reqReg;
        addrNext       = addrReg;
        pfValidNext    = pfValidReg;
        pfDataNext     = pfDataReg;
        dropNext       = dropReg;

        case (stateReg)
            BOOT: begin
                stateNext = REQ;
                reqNext   = 1'b1;
                addrNext  = pcReg;
            end

            REQ: begin
                if (!reqReg) begin
                    // A discarded prefetch has just finished; fetch the real target.
                    reqNext  = 1'b1;
                    addrNext = pcReg;
                end else if (ackSeen) begin
                    reqNext = 1'b0;
                    if (dropReg) begin
                        dropNext = 1'b0;
                    end else begin
                        instrNext      = imem.imemData;
                        instrValidNext = 1'b1;
                        stateNext      = HOLD;
                    end
                end
            end

            HOLD: begin
                if (stepValid) begin
                    pfValidNext = 1'b0;
                    if (PrefetchEn && (pcOp == PCAdd4) && (pfValidReg || ackSeen)) begin
                        // Sequential step served from the prefetch: no bubble.
                        instrNext = pfValidReg ? pfDataReg : imem.imemData;
                        pcNext    = nextPc;
                        reqNext   = 1'b0;
                    end else if (PrefetchEn && reqReg && !ackSeen) begin
                        // Prefetch still in flight; it cannot be withdrawn.
                        pcNext         = nextPc;
                        instrValidNext = 1'b0;
                        stateNext      = REQ;
                        dropNext       = (pcOp != PCAdd4);
                    end else begin
                        pcNext         = nextPc;
                        instrValidNext = 1'b0;
                        stateNext      = REQ;
                        reqNext        = 1'b1;
                        addrNext       = nextPc;
                    end
                end else if (PrefetchEn) begin
                    if (ackSeen) begin
                        pfValidNext = 1'b1;
                        pfDataNext  = imem.imemData;
                        reqNext     = 1'b0;
                    end else if (!reqReg && !pfValidReg) begin
                        reqNext  = 1'b1;
                        addrNext = pcPlus4;
                    end
                end
            end

            default: begin
                stateNext = BOOT;
                reqNext   = 1'b0;
            end
        endcase
    end

    assign pc            = pcReg;
    assign pcReadData    = pcPlus4;
    assign instr         = instrReg;
    assign instrValid    = instrValidReg;
    assign imem.imemReq  = reqReg;
    assign imem.imemAddr = addrReg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a variable-latency memory model answers
// every request, and each presented instruction is checked against a queue.
`timescale 1ns/1ps
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam logic [31:0] ResetPc = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sbEntry_t;

    logic        clk;
    logic        rstn;
    logic [1:0]  pcOp;
    logic [31:0] pcWriteData;
    logic        stepValid;
    logic [31:0] pc;
    logic [31:0] pcReadData;
    logic [31:0] instr;
    logic        instrValid;

    logic        ackDrv;
    logic [31:0] dataDrv;
    int          memDelay;
    int          memCnt;

    sbEntry_t    sbQ[$];
    sbEntry_t    monE;
    logic        prevValid;
    logic [31:0] prevPc;
    logic [31:0] expPc;

    int assertCount = 0;
    int failCount   = 0;

    pc_fetch_unit_if memIf();

    assign memIf.imemAck  = ackDrv & rstn;
    assign memIf.imemData = dataDrv;

    pc_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (ResetPc)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pcOp        (pcOp),
        .pcWriteData (pcWriteData),
        .stepValid   (stepValid),
        .pc          (pc),
        .pcReadData  (pcReadData),
        .instr       (instr),
        .instrValid  (instrValid),
        .imem        (memIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] t;
        t = {a[15:0], a[31:16]};
        return t ^ 32'h0000_0093;
    endfunction

    function automatic logic [31:0] modelNext(input logic [1:0] op, input logic [31:0] p,
                                              input logic [31:0] wd);
        case (op)
            2'd0:    return ResetPc;
            2'd1:    return p + 32'd4;
            2'd2:    return p + wd;
            default: return wd & 32'hFFFF_FFFC;
        endcase
    endfunction

    // Memory: acks a request memDelay cycles after seeing it, data from the address.
    always @(negedge clk) begin
        if (!rstn) begin
            ackDrv = 1'b0;
            memCnt = 0;
        end else if (ackDrv) begin
            ackDrv = 1'b0;
            memCnt = 0;
        end else if (memIf.imemReq) begin
            if (memCnt >= memDelay) begin
                ackDrv  = 1'b1;
                dataDrv = memWord(memIf.imemAddr);
            end else begin
                memCnt++;
            end
        end else begin
            memCnt = 0;
        end
    end

    // Monitor: a new instruction is a rising instrValid or a pc change while valid.
    always @(negedge clk) begin
        if (!rstn) begin
            prevValid = 1'b0;
        end else begin
            if (instrValid && (!prevValid || pc != prevPc)) begin
                if (sbQ.size() == 0) begin
                    checkVal("sbEmpty", 32'(sbQ.size()), 32'd1);
                end else begin
                    monE = sbQ.pop_front();
                    checkVal("pc", pc, monE.pc);
                    checkVal("instr", instr, monE.instr);
                    checkVal("pcReadData", pcReadData, monE.pc + 32'd4);
                    $display("fetch pc=0x%08h instr=0x%08h link=0x%08h", pc, instr, pcReadData);
                end
            end
            prevValid = instrValid;
            prevPc    = pc;
        end
    end

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (!(instrValid && sbQ.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkVal(tag, 32'(sbQ.size()), 32'd0);
    endtask

    // Called at a negedge with instrValid=1; returns at the following negedge.
    task automatic doStep(input logic [1:0] op, input logic [31:0] wd);
        stepValid   = 1'b1;
        pcOp        = op;
        pcWriteData = wd;
        expPc       = modelNext(op, expPc, wd);
        sbQ.push_back('{pc: expPc, instr: memWord(expPc)});
        @(negedge clk);
        stepValid = 1'b0;
    endtask

    task automatic stepChk(input string tag, input logic [1:0] op, input logic [31:0] wd);
        doStep(op, wd);
`ifndef FETCH_PREFETCH_EN
        checkVal({tag, "_req"}, 32'(memIf.imemReq), 32'd1);
        checkVal({tag, "_addr"}, memIf.imemAddr, expPc);
`endif
        waitIdle({tag, "_timeout"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn        = 1'b0;
        stepValid   = 1'b0;
        pcOp        = 2'd0;
        pcWriteData = 32'd0;
        memDelay    = 2;
        memCnt      = 0;
        ackDrv      = 1'b0;
        dataDrv     = 32'd0;
        expPc       = ResetPc;

        repeat (2) @(negedge clk);
        #1;
        checkVal("rstPc", pc, ResetPc);
        checkVal("rstInstr", instr, 32'd0);
        checkVal("rstValid", 32'(instrValid), 32'd0);
        checkVal("rstReq", 32'(memIf.imemReq), 32'd0);
        checkVal("rstAddr", memIf.imemAddr, ResetPc);
        checkVal("rstLink", pcReadData, ResetPc + 32'd4);

        sbQ.push_back('{pc: ResetPc, instr: memWord(ResetPc)});
        #2 rstn = 1'b1;
        @(negedge clk);
        checkVal("bootReq", 32'(memIf.imemReq), 32'd1);
        checkVal("bootAddr", memIf.imemAddr, ResetPc);
        waitIdle("boot_timeout");

        memDelay = 0;
        stepChk("setImm10", PCSetImm, 32'h0000_0010);
        stepChk("addImmNeg", PCAddImm, 32'hFFFF_FFF8);
        stepChk("setImmAlign", PCSetImm, 32'h0000_1003);
        stepChk("setImmTop", PCSetImm, 32'hFFFF_FFFF);
        stepChk("add4Wrap", PCAdd4, 32'h0000_0000);
        stepChk("setImm44", PCSetImm, 32'h0000_0044);
        stepChk("clear", PCClear, 32'h0000_1234);
        stepChk("addImmBig", PCAddImm, 32'h7FFF_FFF0);
        stepChk("add4", PCAdd4, 32'h0000_0000);

`ifndef FETCH_PREFETCH_EN
        // Slow memory: request must hold still, and a step while invalid is ignored.
        memDelay = 5;
        doStep(PCAdd4, 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkVal("waitReq", 32'(memIf.imemReq), 32'd1);
            checkVal("waitAddr", memIf.imemAddr, expPc);
            checkVal("waitPc", pc, expPc);
            stepValid   = (i == 1);
            pcOp        = PCSetImm;
            pcWriteData = 32'h0000_0700;
            @(negedge clk);
        end
        stepValid = 1'b0;
        waitIdle("slow_timeout");
        checkVal("ignoredStepPc", pc, expPc);
`endif

        // Asynchronous reset in the middle of an outstanding fetch.
        memDelay = 6;
        doStep(PCSetImm, 32'h0000_0200);
        #2 rstn = 1'b0;
        #1;
        checkVal("abortReq", 32'(memIf.imemReq), 32'd0);
        checkVal("abortAddr", memIf.imemAddr, ResetPc);
        checkVal("abortPc", pc, ResetPc);
        checkVal("abortValid", 32'(instrValid), 32'd0);
        checkVal("abortInstr", instr, 32'd0);
        checkVal("abortLink", pcReadData, ResetPc + 32'd4);
        sbQ.delete();
        expPc = ResetPc;
        sbQ.push_back('{pc: ResetPc, instr: memWord(ResetPc)});
        memDelay = 1;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        waitIdle("rerun_timeout");

`ifdef FETCH_PREFETCH_EN
        memDelay = 0;
        stepChk("pfSet20", PCSetImm, 32'h0000_0020);
        repeat (4) @(negedge clk);
        doStep(PCAdd4, 32'd0);
        checkVal("pfNoBubble", 32'(instrValid), 32'd1);
        checkVal("pfPc", pc, 32'h0000_0024);
        memDelay = 4;
        @(negedge clk);
        doStep(PCSetImm, 32'h0000_0300);
        checkVal("pfDrainReq", 32'(memIf.imemReq), 32'd1);
        checkVal("pfDrainAddr", memIf.imemAddr, 32'h0000_0028);
        waitIdle("pfBranch_timeout");
`endif

        repeat (3) @(negedge clk);
        checkVal("sbDrain", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
